// File: rtl/contador_min_hora_if.sv
// Bundle of the timekeeping counter's tick/button inputs and BCD time outputs.
interface contador_min_hora_if;
   logic       tick_in;
   logic       set_mode;
   logic       inc_min;
   logic       inc_hour;
   logic [3:0] min_u;
   logic [3:0] min_d;
   logic [3:0] hour_u;
   logic [3:0] hour_d;
   logic       pm;
   logic       hour_pulse;
   logic       day_pulse;

   // Driver side: owns the divider wave, mode level and buttons.
   modport master (
      output tick_in, set_mode, inc_min, inc_hour,
      input  min_u, min_d, hour_u, hour_d, pm, hour_pulse, day_pulse
   );

   // Counter side.
   modport slave (
      input  tick_in, set_mode, inc_min, inc_hour,
      output min_u, min_d, hour_u, hour_d, pm, hour_pulse, day_pulse
   );
endinterface

// File: rtl/contador_min_hora.sv
// Minute/hour BCD timekeeper: counts both edges of the divider wave,
// with a set mode driven by debounced increment buttons.
module contador_min_hora #(
   parameter bit FORMAT_24 = 1'b1
) (
   input logic                clock,
   input logic                reset,
   contador_min_hora_if.slave bus
);

   localparam int unsigned DW = 4;
   localparam logic [DW-1:0] RST_HOUR_D = FORMAT_24 ? DW'(0) : DW'(1);
   localparam logic [DW-1:0] RST_HOUR_U = FORMAT_24 ? DW'(0) : DW'(2);

   logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic          inc_min_q, inc_min_d, inc_hour_q, inc_hour_d;
   logic [DW-1:0] min_u_q, min_u_d, min_d_q, min_d_d;
   logic [DW-1:0] hour_u_q, hour_u_d, hour_d_q, hour_d_d;
   logic          pm_q, pm_d;
   logic          hour_pulse_q, hour_pulse_d, day_pulse_q, day_pulse_d;

   logic          tick_ev, min_btn_ev, hour_btn_ev;
   logic          min_step, hour_step, min_wrap, day_wrap;

   // Edge detection: every divider transition is a minute, buttons count rising edges only.
   always_comb begin
      tick_ev     = s2_q ^ s3_q;
      min_btn_ev  = bus.inc_min & ~inc_min_q;
      hour_btn_ev = bus.inc_hour & ~inc_hour_q;
   end

   // Next-state: BCD minute/hour stepping, set mode diverts steps to the buttons.
   always_comb begin
      s1_d         = bus.tick_in;
      s2_d         = s1_q;
      s3_d         = s2_q;
      inc_min_d    = bus.inc_min;
      inc_hour_d   = bus.inc_hour;
      min_u_d      = min_u_q;
      min_d_d      = min_d_q;
      hour_u_d     = hour_u_q;
      hour_d_d     = hour_d_q;
      pm_d         = pm_q;
      hour_pulse_d = 1'b0;
      day_pulse_d  = 1'b0;
      min_wrap     = 1'b0;
      day_wrap     = 1'b0;

      min_step = bus.set_mode ? min_btn_ev : tick_ev;

      if (min_step) begin
         if (min_u_q == DW'(9)) begin
            min_u_d = '0;
            if (min_d_q == DW'(5)) begin
               min_d_d  = '0;
               min_wrap = 1'b1;
            end else begin
               min_d_d = DW'(min_d_q + DW'(1));
            end
         end else begin
            min_u_d = DW'(min_u_q + DW'(1));
         end
      end

      // In set mode the minute wrap never carries into the hours.
      hour_step    = bus.set_mode ? hour_btn_ev : min_wrap;
      hour_pulse_d = ~bus.set_mode & min_wrap;

      if (hour_step) begin
         if (FORMAT_24) begin
            if (hour_d_q == DW'(2) && hour_u_q == DW'(3)) begin
               hour_d_d = '0;
               hour_u_d = '0;
               day_wrap = 1'b1;
            end else if (hour_u_q == DW'(9)) begin
               hour_u_d = '0;
               hour_d_d = DW'(hour_d_q + DW'(1));
            end else begin
               hour_u_d = DW'(hour_u_q + DW'(1));
            end
         end else begin
            if (hour_d_q == DW'(1) && hour_u_q == DW'(2)) begin
               hour_d_d = '0;
               hour_u_d = DW'(1);
            end else if (hour_d_q == DW'(1) && hour_u_q == DW'(1)) begin
               hour_u_d = DW'(2);
               pm_d     = ~pm_q;
               day_wrap = pm_q;
            end else if (hour_u_q == DW'(9)) begin
               hour_u_d = '0;
               hour_d_d = DW'(1);
            end else begin
               hour_u_d = DW'(hour_u_q + DW'(1));
            end
         end
      end

      day_pulse_d = ~bus.set_mode & day_wrap;
   end

   // State register; reset preloads the synchronizer and button history with the live inputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q         <= bus.tick_in;
         s2_q         <= bus.tick_in;
         s3_q         <= bus.tick_in;
         inc_min_q    <= bus.inc_min;
         inc_hour_q   <= bus.inc_hour;
         min_u_q      <= '0;
         min_d_q      <= '0;
         hour_u_q     <= RST_HOUR_U;
         hour_d_q     <= RST_HOUR_D;
         pm_q         <= 1'b0;
         hour_pulse_q <= 1'b0;
         day_pulse_q  <= 1'b0;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         inc_min_q    <= inc_min_d;
         inc_hour_q   <= inc_hour_d;
         min_u_q      <= min_u_d;
         min_d_q      <= min_d_d;
         hour_u_q     <= hour_u_d;
         hour_d_q     <= hour_d_d;
         pm_q         <= pm_d;
         hour_pulse_q <= hour_pulse_d;
         day_pulse_q  <= day_pulse_d;
      end
   end

   assign bus.min_u      = min_u_q;
   assign bus.min_d      = min_d_q;
   assign bus.hour_u     = hour_u_q;
   assign bus.hour_d     = hour_d_q;
   assign bus.pm         = pm_q;
   assign bus.hour_pulse = hour_pulse_q;
   assign bus.day_pulse  = day_pulse_q;

endmodule
